prop_clkctrl: RTL and testbench

Parametrised clock-control block for the Propeller 1 core: a single-clock successor to the divide-by-accumulator clock logic, generating one-cycle clock *enables* (`cog_en`, `pll_en`) rather than derived clocks. Mode changes requested by the core are deferred to a divider wrap boundary, so enable periods never glitch. The block also provides the core reset (`nres`), including an optional DTR reset-pulse stretcher. It sits between the board top level and `dig`.

---
 rtl/prop_clk_pkg.sv | 47 ++++
 rtl/prop_clkctrl_if.sv | 12 +
 rtl/prop_rst_stretch.sv | 59 +++++
 rtl/prop_clkctrl.sv | 112 +++++++++++
 tb/tb_prop_clkctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prop_clk_pkg.sv
// Shared encodings, FSM states and the divider increment table for prop_clkctrl.
package prop_clk_pkg;

   typedef enum logic [2:0] {
      RCFAST = 3'd0,
      RCSLOW = 3'd1,
      XINPUT = 3'd2,
      XTAL1  = 3'd3,
      PLL2   = 3'd4,
      PLL4   = 3'd5,
      PLL8   = 3'd6,
      PLL16  = 3'd7
   } clksel_e;

   typedef enum logic [1:0] {
      S_RST  = 2'd0,
      S_RUN  = 2'd1,
      S_PEND = 2'd2
   } state_e;

   localparam int DIV_W_MIN   = 6;
   localparam int SYNC_STAGES = 2;

   // Accumulator step for a clock register value; zero means the divider is stalled.
   function automatic logic [31:0] clk_inc(input logic [7:0] cfg, input int div_w);
      logic        p;
      clksel_e     sel;
      logic [31:0] one;
      p   = (cfg[6:5] == 2'b11);
      sel = clksel_e'(cfg[2:0]);
      one = 32'd1;
      if (p && sel == PLL16)
         return one << (div_w - 1);
      else if (p && sel == PLL8)
         return one << (div_w - 2);
      else if (p && sel == PLL4)
         return one << (div_w - 3);
      else if ((p && sel == PLL2) || sel == RCFAST)
         return one << (div_w - 4);
      else if ((p && sel == XTAL1) || (cfg[5] && sel == XINPUT))
         return one << (div_w - 5);
      else if (sel == RCSLOW)
         return one;
      return 32'd0;
   endfunction

endpackage

// File: rtl/prop_clkctrl_if.sv
// Core-facing clock-control signals: mode request in, enables/reset/status out.
interface prop_clkctrl_if;
   logic [7:0] cfg;
   logic       cog_en;
   logic       pll_en;
   logic       nres;
   logic [7:0] cfg_act;
   logic       sw_pend;

   modport master (output cfg, input cog_en, pll_en, nres, cfg_act, sw_pend);
   modport slave  (input cfg, output cog_en, pll_en, nres, cfg_act, sw_pend);
endinterface

// File: rtl/prop_rst_stretch.sv
// Core reset source: 2-flop synchroniser, plus the DTR pulse stretcher when
// PROP_CLKCTRL_DTR_STRETCH_EN is defined (otherwise inp_resn is used directly).
module prop_rst_stretch
   import prop_clk_pkg::*;
#(
   parameter int                   STRETCH_W   = 24,
   parameter logic [STRETCH_W-1:0] STRETCH_CNT = 24'hFFFFF
) (
   input  logic clk,
   input  logic res,
   output logic core_res,
`ifdef PROP_CLKCTRL_DTR_STRETCH_EN
   input  logic dtr
`else
   input  logic inp_resn
`endif
);

   if (STRETCH_CNT == '0) begin : g_bad_cnt
      $error("STRETCH_CNT must be non-zero");
   end

   logic [SYNC_STAGES-1:0] sync_reg;

`ifdef PROP_CLKCTRL_DTR_STRETCH_EN
   logic [STRETCH_W-1:0] cnt_reg;
   logic                 done_reg;
   logic                 dtr_s;

   always_ff @(posedge clk) begin
      if (res) sync_reg <= '0;
      else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], dtr};
   end

   assign dtr_s = sync_reg[SYNC_STAGES-1];

   // Stretch holds reset for exactly STRETCH_CNT cycles of asserted DTR.
   always_ff @(posedge clk) begin
      if (res || !dtr_s) begin
         cnt_reg  <= '0;
         done_reg <= 1'b0;
      end else if (!done_reg) begin
         if (cnt_reg == STRETCH_CNT - 1'b1) done_reg <= 1'b1;
         else                               cnt_reg  <= cnt_reg + 1'b1;
      end
   end

   assign core_res = dtr_s & ~done_reg;
`else
   // Idle level of an active-low reset is 1, so the core is not held after res.
   always_ff @(posedge clk) begin
      if (res) sync_reg <= '1;
      else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], inp_resn};
   end

   assign core_res = ~sync_reg[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/prop_clkctrl.sv
// Propeller clock control: cog/PLL clock enables from a divide-by-accumulator, with
// mode switches deferred to a wrap. Define PROP_CLKCTRL_DTR_STRETCH_EN for DTR reset.
module prop_clkctrl
   import prop_clk_pkg::*;
#(
   parameter int                   DIV_W       = 13,
   parameter int                   STRETCH_W   = 24,
   parameter logic [STRETCH_W-1:0] STRETCH_CNT = 24'hFFFFF
) (
   input  logic clk,
   input  logic res,
`ifdef PROP_CLKCTRL_DTR_STRETCH_EN
   input  logic dtr,
`else
   input  logic inp_resn,
`endif
   prop_clkctrl_if.slave bus
);

   if (DIV_W < DIV_W_MIN) begin : g_bad_div
      $error("DIV_W must be at least 6");
   end

   localparam logic [DIV_W-1:0] INC_HALF = {1'b1, {(DIV_W-1){1'b0}}};

   state_e           state_reg, state_next;
   logic [DIV_W-1:0] acc_reg, acc_next, inc, inc_act;
   logic [7:0]       cfg_q_reg, cfg_act_reg, cfg_act_next;
   logic             cog_en_reg, pll_en_reg, nres_reg;
   logic             cog_en_next, pll_en_next, nres_next;
   logic             core_res;

   prop_rst_stretch #(
      .STRETCH_W   (STRETCH_W),
      .STRETCH_CNT (STRETCH_CNT)
   ) u_rst (
      .clk      (clk),
      .res      (res),
      .core_res (core_res),
`ifdef PROP_CLKCTRL_DTR_STRETCH_EN
      .dtr      (dtr)
`else
      .inp_resn (inp_resn)
`endif
   );

   // While the core is held in reset the divider free-runs at half rate.
   always_comb begin
      inc_act     = DIV_W'(clk_inc(cfg_act_reg, DIV_W));
      inc         = (state_reg == S_RST) ? INC_HALF : inc_act;
      acc_next    = acc_reg + inc;
      cog_en_next = ~acc_reg[DIV_W-1] & acc_next[DIV_W-1];
      pll_en_next = (inc_act == INC_HALF) | (~acc_reg[DIV_W-2] & acc_next[DIV_W-2]);
      nres_next   = cog_en_next ? (~core_res & ~cfg_act_reg[7]) : nres_reg;
   end

   // The reset-request bit bypasses deferral; mode bits only change at a wrap.
   always_comb begin
      state_next   = state_reg;
      cfg_act_next = {cfg_q_reg[7], cfg_act_reg[6:0]};
      case (state_reg)
         S_RST: begin
            if (!core_res) begin
               state_next   = S_RUN;
               cfg_act_next = cfg_q_reg;
            end
         end
         S_RUN: begin
            if (core_res)
               state_next = S_RST;
            else if (cfg_q_reg[6:0] != cfg_act_reg[6:0])
               state_next = S_PEND;
         end
         S_PEND: begin
            if (core_res) begin
               state_next = S_RST;
            end else if (acc_next == '0 || inc_act == '0) begin
               state_next   = S_RUN;
               cfg_act_next = cfg_q_reg;
            end
         end
         default: state_next = S_RST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_reg   <= S_RST;
         acc_reg     <= '0;
         cfg_q_reg   <= '0;
         cfg_act_reg <= '0;
         cog_en_reg  <= 1'b0;
         pll_en_reg  <= 1'b0;
         nres_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         acc_reg     <= acc_next;
         cfg_q_reg   <= bus.cfg;
         cfg_act_reg <= cfg_act_next;
         cog_en_reg  <= cog_en_next;
         pll_en_reg  <= pll_en_next;
         nres_reg    <= nres_next;
      end
   end

   assign bus.cog_en  = cog_en_reg;
   assign bus.pll_en  = pll_en_reg;
   assign bus.nres    = nres_reg;
   assign bus.cfg_act = cfg_act_reg;
   assign bus.sw_pend = (state_reg == S_PEND);

endmodule

// File: tb/tb_prop_clkctrl.sv
// Directed bench for prop_clkctrl: mode table plus deferral, reset and stall sequences.
module tb_prop_clkctrl;

   logic clk;
   logic res;
`ifdef PROP_CLKCTRL_DTR_STRETCH_EN
   logic dtr;
`else
   logic inp_resn;
`endif

   prop_clkctrl_if bus ();

   prop_clkctrl #(
      .DIV_W       (13),
      .STRETCH_W   (24),
      .STRETCH_CNT (24'd16)
   ) dut (
      .clk      (clk),
      .res      (res),
`ifdef PROP_CLKCTRL_DTR_STRETCH_EN
      .dtr      (dtr),
`else
      .inp_resn (inp_resn),
`endif
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] cfg;
      logic [7:0] act;
      int         cog_per;
      int         pll_per;   // 1 means pll_en constantly high
   } vec_t;

   localparam int NV = 8;
   vec_t vt [NV];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
      else
         $display("ok   %s: %0d", name, got);
   endtask

   task automatic wait_act(input logic [7:0] want, input int budget);
      for (int t = 0; t < budget; t++) begin
         @(negedge clk);
         if (bus.cfg_act == want) break;
      end
   endtask

   task automatic wait_nres(input logic want, input int budget, output int cyc);
      cyc = -1;
      for (int t = 1; t <= budget; t++) begin
         @(negedge clk);
         if (bus.nres == want) begin
            cyc = t;
            break;
         end
      end
   endtask

   // Period between the last two of n pulses; -1 if the budget expires first.
   task automatic wait_pulse(input bit use_pll, input int n, input int budget, output int per);
      int seen, last;
      logic p;
      seen = 0; last = -1; per = -1;
      for (int t = 0; t < budget && seen < n; t++) begin
         @(negedge clk);
         p = use_pll ? bus.pll_en : bus.cog_en;
         if (p) begin
            if (last >= 0) per = t - last;
            last = t;
            seen++;
         end
      end
      if (seen < n) per = -1;
   endtask

   task automatic count_en(input int cycles, output int nc, output int np);
      nc = 0; np = 0;
      for (int t = 0; t < cycles; t++) begin
         @(negedge clk);
         nc += int'(bus.cog_en);
         np += int'(bus.pll_en);
      end
   endtask

   task automatic pend_len(input int budget, output int len);
      len = 0;
      for (int t = 0; t < budget; t++) begin
         @(negedge clk);
         if (bus.sw_pend) len++;
         else if (len > 0) break;
      end
   endtask

   initial begin
      int per, mn, len, t, nc, np, last;
      bit seen;

      vt[0] = '{8'h00, 8'h00, 16, 8};
      vt[1] = '{8'h6F, 8'h6F, 2, 1};
      vt[2] = '{8'h6E, 8'h6E, 4, 2};
      vt[3] = '{8'h6D, 8'h6D, 8, 4};
      vt[4] = '{8'h6C, 8'h6C, 16, 8};
      vt[5] = '{8'h6B, 8'h6B, 32, 16};
      vt[6] = '{8'h22, 8'h22, 32, 16};
      vt[7] = '{8'h64, 8'h64, 16, 8};

      res     = 1'b1;
      bus.cfg = 8'h00;
`ifdef PROP_CLKCTRL_DTR_STRETCH_EN
      dtr = 1'b0;
`else
      inp_resn = 1'b1;
`endif
      repeat (3) @(negedge clk);
      check("rst_cog_en", int'(bus.cog_en), 0);
      check("rst_pll_en", int'(bus.pll_en), 0);
      check("rst_nres", int'(bus.nres), 0);
      check("rst_sw_pend", int'(bus.sw_pend), 0);
      check("rst_cfg_act", int'(bus.cfg_act), 0);
      res = 1'b0;

      for (int i = 0; i < NV; i++) begin
         bus.cfg = vt[i].cfg;
         wait_act(vt[i].act, 300);
         check($sformatf("vec%0d_act", i), int'(bus.cfg_act), int'(vt[i].act));
         wait_pulse(1'b0, 3, 200, per);
         check($sformatf("vec%0d_cog_per", i), per, vt[i].cog_per);
         if (vt[i].pll_per == 1) begin
            count_en(8, nc, np);
            check($sformatf("vec%0d_pll_const", i), np, 8);
         end else begin
            wait_pulse(1'b1, 2, 100, per);
            check($sformatf("vec%0d_pll_per", i), per, vt[i].pll_per);
         end
         check($sformatf("vec%0d_sw_pend", i), int'(bus.sw_pend), 0);
         check($sformatf("vec%0d_nres", i), int'(bus.nres), 1);
      end

      // PLL16 switch from RCFAST lands on a wrap: first cog_en one cycle later.
      bus.cfg = 8'h00;
      wait_act(8'h00, 300);
      wait_pulse(1'b0, 2, 100, per);
      bus.cfg = 8'h6F;
      pend_len(60, len);
      check("pll16_pend_1to16", int'(len >= 1 && len <= 16), 1);
      check("pll16_act_at_wrap", int'(bus.cfg_act), 8'h6F);
      check("pll16_no_cog_at_wrap", int'(bus.cog_en), 0);
      @(negedge clk);
      check("pll16_first_cog", int'(bus.cog_en), 1);
      count_en(10, nc, np);
      check("pll16_pll_const", np, 10);
      check("pll16_cog_count", nc, 5);

      // Reset request bit in PLL16: nres drops, mode unchanged.
      bus.cfg = 8'hEF;
      wait_nres(1'b0, 8, t);
      check("cfg7_nres_low", int'(bus.nres), 0);
      check("cfg7_latency", int'(t >= 1 && t <= 5), 1);
      check("cfg7_act", int'(bus.cfg_act), 8'hEF);
      check("cfg7_sw_pend", int'(bus.sw_pend), 0);
      count_en(8, nc, np);
      check("cfg7_cog_count", nc, 4);
      bus.cfg = 8'h6F;
      wait_nres(1'b1, 8, t);
      check("cfg7_nres_back", int'(bus.nres), 1);

      // Back-to-back requests within one pending window: only the last applies.
      bus.cfg = 8'h6C;
      wait_act(8'h6C, 100);
      wait_pulse(1'b0, 1, 100, per);
      bus.cfg = 8'h6E;
      @(negedge clk);
      bus.cfg = 8'h6D;
      seen = 1'b0; last = 0; mn = 1000; per = -1;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (bus.cfg_act == 8'h6E) seen = 1'b1;
         if (bus.cog_en) begin
            per = k - last;
            if (per < mn) mn = per;
            last = k;
         end
      end
      check("latest_wins_no_6e", int'(seen), 0);
      check("latest_wins_act", int'(bus.cfg_act), 8'h6D);
      check("latest_wins_min_per", mn, 8);
      check("latest_wins_per", per, 8);

`ifdef PROP_CLKCTRL_DTR_STRETCH_EN
      dtr = 1'b1;
      wait_nres(1'b0, 20, t);
      check("dtr_nres_low", int'(bus.nres), 0);
      wait_nres(1'b1, 40, t);
      check("dtr_stretch_len", int'(t >= 14 && t <= 17), 1);
      dtr = 1'b0;
      repeat (4) @(negedge clk);
      dtr = 1'b1;
      wait_nres(1'b0, 20, t);
      check("dtr2_nres_low", int'(bus.nres), 0);
      repeat (3) @(negedge clk);
      dtr = 1'b0;
      wait_nres(1'b1, 20, t);
      check("dtr_drop_release", int'(t >= 1 && t <= 8), 1);
`else
      // Core reset while a switch is pending drops the switch until release.
      bus.cfg  = 8'h6C;
      inp_resn = 1'b0;
      wait_nres(1'b0, 16, t);
      check("ext_rst_nres_low", int'(bus.nres), 0);
      wait_pulse(1'b0, 3, 20, per);
      check("ext_rst_cog_per", per, 2);
      check("ext_rst_act_held", int'(bus.cfg_act), 8'h6D);
      check("ext_rst_sw_pend", int'(bus.sw_pend), 0);
      inp_resn = 1'b1;
      wait_act(8'h6C, 12);
      check("ext_rst_exit_act", int'(bus.cfg_act), 8'h6C);
      wait_nres(1'b1, 40, t);
      check("ext_rst_nres_back", int'(bus.nres), 1);
`endif

      // Stalled divider, then an immediate switch to RCSLOW.
      bus.cfg = 8'h02;
      wait_act(8'h02, 100);
      check("stall_act", int'(bus.cfg_act), 8'h02);
      count_en(40, nc, np);
      check("stall_cog_count", nc, 0);
      check("stall_pll_count", np, 0);
      bus.cfg = 8'h01;
      pend_len(10, len);
      check("rcslow_pend_len", len, 1);
      check("rcslow_act", int'(bus.cfg_act), 8'h01);
      wait_pulse(1'b0, 2, 20000, per);
      check("rcslow_cog_per", per, 8192);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
